// File: rtl/fmap_pingpong_buffer.sv
// fmap_pingpong_buffer
// Double-buffered feature-map store that sits between two conv2d layers.
// The producer writes one bank while the consumer reads the other. Ownership
// of the two banks changes on the frame-complete pulses (wr_done / rd_done).
//
// Bank states:
//   state | meaning
//   FREE  | owned by the producer, or unused
//   FULL  | holds a complete frame, waiting to be read or being read
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   wr_en/wr_we     producer access enable / write strobe
//   wr_addr/wr_data producer element address / data
//   wr_done         producer frame-complete pulse
//   wr_ready        the producer's current bank is FREE
//   rd_en/rd_addr   consumer read request / address
//   rd_data/rd_valid read data, valid one cycle after the request
//   rd_done         consumer frame-finished pulse
//   rd_ready        the consumer's current bank is FULL
//   frames_pending  number of FULL banks (0..2)
//   err             sticky: [0] producer access while !wr_ready,
//                   [1] consumer access while !rd_ready, [2] address >= DEPTH
module fmap_pingpong_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_done,
  output logic                  rd_ready,
  output logic [1:0]            frames_pending,
  output logic [2:0]            err
);

  typedef enum logic {FREE = 1'b0, FULL = 1'b1} bank_state_t;

  // One extra bit so that DEPTH itself is representable when DEPTH is a
  // power of two.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  bank_state_t state [2];
  logic        wsel;
  logic        rsel;

  logic wr_attempt, rd_attempt;
  logic wr_in_range, rd_in_range;
  logic do_write, do_read;
  logic do_wr_done, do_rd_done;

  assign wr_ready       = (state[wsel] == FREE);
  assign rd_ready       = (state[rsel] == FULL);
  assign frames_pending = {1'b0, state[0] == FULL} + {1'b0, state[1] == FULL};

  assign wr_attempt  = wr_en & wr_we;
  assign rd_attempt  = rd_en;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);

  assign do_write   = wr_attempt & wr_ready & wr_in_range & ~rst;
  assign do_read    = rd_attempt & rd_ready & rd_in_range;
  assign do_wr_done = wr_done & wr_ready;
  assign do_rd_done = rd_done & rd_ready;

  // Storage is never reset. The write uses the pre-swap wsel, so a write
  // issued together with wr_done lands in the bank being completed.
  always_ff @(posedge clk) begin
    if (do_write) begin
      if (wsel) mem1[wr_addr] <= wr_data;
      else      mem0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state[0] <= FREE;
      state[1] <= FREE;
      wsel     <= 1'b0;
      rsel     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= '0;
    end else begin
      // The read is served from the pre-swap rsel, so a read issued together
      // with rd_done still returns data from the frame being released.
      rd_valid <= do_read;
      if (do_read) rd_data <= rsel ? mem1[rd_addr] : mem0[rd_addr];

      // When both handshakes are accepted in one cycle they always target
      // different banks: wsel's bank is FREE and rsel's bank is FULL.
      if (do_wr_done) begin
        state[wsel] <= FULL;
        wsel        <= ~wsel;
      end
      if (do_rd_done) begin
        state[rsel] <= FREE;
        rsel        <= ~rsel;
      end

      err <= err | {(wr_attempt & ~wr_in_range) | (rd_attempt & ~rd_in_range),
                    (rd_attempt | rd_done) & ~rd_ready,
                    (wr_attempt | wr_done) & ~wr_ready};
    end
  end

endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
module tb_fmap_pingpong_buffer;
  localparam int DW = 16;
  localparam int DEPTH = 12;
  localparam int AW = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  logic wr_en, wr_we, wr_done, rd_en, rd_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic rd_valid, wr_ready, rd_ready;
  logic [1:0] frames_pending;
  logic [2:0] err;

  fmap_pingpong_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_done(rd_done), .rd_ready(rd_ready),
    .frames_pending(frames_pending), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Monitor: every rd_valid must match the oldest expected read, one cycle
  // after it was issued.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid actual=1 expected=0 data=%0h", rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic do_wr(input int a, input logic [DW-1:0] d);
    wr_en = 1; wr_we = 1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 0; wr_we = 0;
  endtask

  task automatic do_rd(input int a, input logic [DW-1:0] d, input bit expect_data);
    rd_en = 1; rd_addr = AW'(a);
    if (expect_data) push_rd(d);
    tick();
    rd_en = 0;
  endtask

  task automatic status(input string tag, input logic wr_r, input logic rd_r,
                        input logic [1:0] fp, input logic [2:0] e);
    chk({tag, "_wr_ready"}, wr_ready, wr_r);
    chk({tag, "_rd_ready"}, rd_ready, rd_r);
    chk({tag, "_frames_pending"}, frames_pending, fp);
    chk({tag, "_err"}, err, e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; wr_en = 0; wr_we = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
    rd_en = 0; rd_addr = '0; rd_done = 0;
    tick(); tick();
    rst = 0;
    status("reset", 1, 0, 0, 3'b000);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);

    // Fill bank0 with 0x0100+addr, complete the frame
    for (int i = 0; i < 8; i++) do_wr(i, 16'h0100 + 16'(i));
    wr_done = 1; tick(); wr_done = 0;
    status("fill0", 1, 1, 1, 3'b000);
    do_rd(5, 16'h0105, 1);
    do_rd(0, 16'h0100, 1);
    do_rd(7, 16'h0107, 1);

    // Ping-pong: read bank0 every cycle while filling bank1
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_we = 1; wr_addr = AW'(i); wr_data = 16'h0200 + 16'(i);
      rd_en = 1; rd_addr = AW'(i); push_rd(16'h0100 + 16'(i));
      tick();
    end
    wr_en = 0; wr_we = 0; rd_en = 0;
    wr_done = 1; tick(); wr_done = 0;
    status("both_full", 0, 1, 2, 3'b000);

    // Overflow: write with both banks full is dropped
    do_wr(0, 16'hDEAD);
    status("overflow", 0, 1, 2, 3'b001);
    do_rd(0, 16'h0100, 1);

    // Release bank0, consumer moves to bank1
    rd_done = 1; tick(); rd_done = 0;
    status("swap_rd", 1, 1, 1, 3'b001);
    do_rd(3, 16'h0203, 1);

    // Fill bank0 partially, then simultaneous wr_done (with a write) and
    // rd_done (with a read from the old bank)
    for (int i = 0; i < 4; i++) do_wr(i, 16'h0300 + 16'(i));
    wr_en = 1; wr_we = 1; wr_addr = AW'(4); wr_data = 16'h0304; wr_done = 1;
    rd_en = 1; rd_addr = AW'(1); push_rd(16'h0201); rd_done = 1;
    tick();
    wr_en = 0; wr_we = 0; wr_done = 0; rd_en = 0; rd_done = 0;
    status("simul_done", 1, 1, 1, 3'b001);
    do_rd(2, 16'h0302, 1);
    do_rd(4, 16'h0304, 1);

    // Out-of-range write and read
    do_wr(DEPTH, 16'hBEEF);
    status("wr_oob", 1, 1, 1, 3'b101);
    do_rd(DEPTH, 16'h0, 0);
    chk("rd_oob_valid", rd_valid, 0);
    chk("rd_oob_data_hold", rd_data, 16'h0304);

    // Reset during a read burst
    do_rd(0, 16'h0300, 1);
    rd_en = 1; rd_addr = AW'(1); rst = 1;
    tick();
    rd_en = 0; rst = 0;
    chk("midrst_rd_valid", rd_valid, 0);
    status("midrst", 1, 0, 0, 3'b000);

    // Underflow from reset
    do_rd(2, 16'h0, 0);
    chk("underflow_rd_valid", rd_valid, 0);
    status("underflow", 1, 0, 0, 3'b010);
    rd_done = 1; tick(); rd_done = 0;
    status("underflow_done", 1, 0, 0, 3'b010);

    // New frame in bank0; consumer still on bank0, addr1 keeps old data
    do_wr(0, 16'h0400);
    wr_done = 1; tick(); wr_done = 0;
    status("refill", 1, 1, 1, 3'b010);
    do_rd(0, 16'h0400, 1);
    do_rd(1, 16'h0301, 1);

    tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
